regbus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the clock master's shared register bus (7-bit address, 8-bit data, single write strobe). It sits between the register bank and two bus masters: port 0 is the SPI front-end, and port 1 is a local master such as a sequencer or a second host link. It serialises their accesses into single-beat register transactions with round-robin fairness. It returns read data and a one-cycle acknowledge to the winning master.

---
 rtl/regbus_arbiter_pkg.sv | 18 +
 rtl/regbus_arbiter.sv | 145 ++++++++++++++
 tb/tb_regbus_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regbus_arbiter_pkg.sv
// Shared defaults and the round-robin pick for the two-master register bus arbiter.
package regbus_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 7;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    // On a tie the master that was not served last wins; otherwise the sole requester.
    function automatic master_e rr_pick(input logic req0, input logic req1, input master_e last);
        if (req0 && req1) return (last == MST_M1) ? MST_M0 : MST_M1;
        return req1 ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/regbus_arbiter.sv
// Two-master round-robin arbiter that serialises single-beat accesses onto the
// shared register bus and returns read data with a one-cycle ack.
module regbus_arbiter
    import regbus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_req,
    input  logic                  i_m0_wr,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    output logic                  o_m0_ack,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    input  logic                  i_m1_req,
    input  logic                  i_m1_wr,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    output logic                  o_m1_ack,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    input  logic [DATA_WIDTH-1:0] i_data_read_bus,
    output logic [ADDR_WIDTH-1:0] o_addr_bus,
    output logic [DATA_WIDTH-1:0] o_data_write_bus,
    output logic                  o_wr_enable_bus,
    output logic [1:0]            o_grant,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    master_e               last_q, last_d;
    master_e               win;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  capture;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= MST_M1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 2'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        win      = rr_pick(i_m0_req, i_m1_req, last_q);
        case (state_q)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    grant_d = (win == MST_M1) ? 2'b10 : 2'b01;
                    last_d  = win;
                    wr_d    = (win == MST_M1) ? i_m1_wr    : i_m0_wr;
                    addr_d  = (win == MST_M1) ? i_m1_addr  : i_m0_addr;
                    wdata_d = (win == MST_M1) ? i_m1_wdata : i_m0_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_ACK;
                end else if (READ_LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ACK: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the owner's rdata register is touched, and only by a read capture.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (capture) begin
            if (grant_q[1]) rdata1_d = i_data_read_bus;
            else            rdata0_d = i_data_read_bus;
        end
    end

    assign o_busy           = (state_q != ST_IDLE);
    assign o_grant          = grant_q;
    assign o_addr_bus       = o_busy ? addr_q  : '0;
    assign o_data_write_bus = o_busy ? wdata_q : '0;
    assign o_wr_enable_bus  = (state_q == ST_ISSUE) && wr_q;
    assign o_m0_ack         = (state_q == ST_ACK) && grant_q[0];
    assign o_m1_ack         = (state_q == ST_ACK) && grant_q[1];
    assign o_m0_rdata       = rdata0_q;
    assign o_m1_rdata       = rdata1_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench: four arbiters with READ_LATENCY 0..3 share stimulus, each
// with its own request lines and a combinational register bank.
module tb_regbus_arbiter;

    localparam int NDUT = 4;

    logic       clk;
    logic       rst;
    logic       m0_req [NDUT];
    logic       m1_req [NDUT];
    logic       m0_wr, m1_wr;
    logic [6:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_ack [NDUT];
    logic       m1_ack [NDUT];
    logic [7:0] m0_rdata [NDUT];
    logic [7:0] m1_rdata [NDUT];
    logic [7:0] rbus [NDUT];
    logic [6:0] abus [NDUT];
    logic [7:0] wdbus [NDUT];
    logic       wen [NDUT];
    logic [1:0] grant [NDUT];
    logic       busy [NDUT];

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] bank(input logic [6:0] a);
        return (a == 7'h05) ? 8'h3C : ({1'b0, a} ^ 8'hA7);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign rbus[g] = bank(abus[g]);
        regbus_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .READ_LATENCY(g)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_m0_req(m0_req[g]), .i_m0_wr(m0_wr), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
            .o_m0_ack(m0_ack[g]), .o_m0_rdata(m0_rdata[g]),
            .i_m1_req(m1_req[g]), .i_m1_wr(m1_wr), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
            .o_m1_ack(m1_ack[g]), .o_m1_rdata(m1_rdata[g]),
            .i_data_read_bus(rbus[g]), .o_addr_bus(abus[g]), .o_data_write_bus(wdbus[g]),
            .o_wr_enable_bus(wen[g]), .o_grant(grant[g]), .o_busy(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_reqs();
        for (int g = 0; g < NDUT; g++) begin
            m0_req[g] = 1'b0;
            m1_req[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int acks;
        rst = 1'b0;
        clr_reqs();
        m0_wr = 1'b0; m1_wr = 1'b0;
        m0_addr = '0; m1_addr = '0;
        m0_wdata = '0; m1_wdata = '0;
        do_reset();

        // Reset state
        chk("rst_busy",   busy[1],     0);
        chk("rst_grant",  grant[1],    0);
        chk("rst_addr",   abus[1],     0);
        chk("rst_wdata",  wdbus[1],    0);
        chk("rst_wen",    wen[1],      0);
        chk("rst_rdata0", m0_rdata[1], 0);
        chk("rst_rdata1", m1_rdata[1], 0);

        // Single write from m0
        m0_req[1] = 1'b1; m0_wr = 1'b1; m0_addr = 7'h12; m0_wdata = 8'hA5;
        tick();
        chk("wr_strobe", wen[1],   1);
        chk("wr_addr",   abus[1],  7'h12);
        chk("wr_data",   wdbus[1], 8'hA5);
        chk("wr_grant",  grant[1], 2'b01);
        chk("wr_ack_e1", m0_ack[1], 0);
        tick();
        chk("wr_strobe_off", wen[1],    0);
        chk("wr_ack0",       m0_ack[1], 1);
        chk("wr_ack1",       m1_ack[1], 0);
        m0_req[1] = 1'b0;
        tick();
        chk("wr_idle_busy",  busy[1],     0);
        chk("wr_idle_grant", grant[1],    0);
        chk("wr_no_rdata",   m0_rdata[1], 0);
        tick();
        chk("wr_no_regrant", busy[1], 0);

        // Single read from m1, latency 1
        m1_req[1] = 1'b1; m1_wr = 1'b0; m1_addr = 7'h05;
        tick();
        chk("rd_grant",  grant[1], 2'b10);
        chk("rd_no_wen", wen[1],   0);
        chk("rd_addr",   abus[1],  7'h05);
        tick();
        chk("rd_ack_e2", m1_ack[1], 0);
        tick();
        chk("rd_ack_e3", m1_ack[1],   1);
        chk("rd_data",   m1_rdata[1], 8'h3C);
        chk("rd_ack0",   m0_ack[1],   0);
        m1_req[1] = 1'b0;
        tick();

        // Latency sweep: each DUT acks at sampling edge + RL + 2
        for (int g = 0; g < NDUT; g++) m1_req[g] = 1'b1;
        m1_addr = 7'h2A;
        for (int k = 1; k <= 6; k++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                chk($sformatf("sweep_ack_rl%0d_c%0d", g, k), m1_ack[g], (k == g + 2) ? 1 : 0);
                if (k == g + 2) begin
                    chk($sformatf("sweep_data_rl%0d", g), m1_rdata[g], 8'h8D);
                    m1_req[g] = 1'b0;
                end
            end
        end
        tick();

        // Reset in the middle of a read (WAIT on the latency-1 instance)
        m0_req[1] = 1'b1; m0_wr = 1'b0; m0_addr = 7'h05;
        tick();
        tick();
        chk("mid_busy_pre", busy[1], 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy",   busy[1],     0);
        chk("mid_grant",  grant[1],    0);
        chk("mid_addr",   abus[1],     0);
        chk("mid_wen",    wen[1],      0);
        chk("mid_ack0",   m0_ack[1],   0);
        chk("mid_rdata1", m1_rdata[1], 0);
        m0_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            acks += int'(m0_ack[1]) + int'(m1_ack[1]);
        end
        chk("mid_no_ack", acks, 0);
        m0_req[1] = 1'b1; m0_addr = 7'h33;
        tick();
        tick();
        chk("fresh_ack_e2", m0_ack[1], 0);
        tick();
        chk("fresh_ack",  m0_ack[1],   1);
        chk("fresh_data", m0_rdata[1], 8'h94);
        m0_req[1] = 1'b0;
        tick();

        // Request dropped during WAIT (latency-3 instance)
        m0_req[3] = 1'b1; m0_addr = 7'h40;
        tick();
        tick();
        m0_req[3] = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            acks += int'(m0_ack[3]);
        end
        chk("drop_one_ack", acks, 1);
        chk("drop_data",    m0_rdata[3], 8'hE7);
        chk("drop_busy",    busy[3], 0);

        // Ties after reset: strict alternation starting with m0
        do_reset();
        m0_wr = 1'b1; m0_addr = 7'h10; m0_wdata = 8'h11;
        m1_wr = 1'b1; m1_addr = 7'h20; m1_wdata = 8'h22;
        m0_req[1] = 1'b1; m1_req[1] = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = 0;
            while (grant[1] == 2'b00 && n < 8) begin tick(); n++; end
            chk($sformatf("tie_grant_%0d", r), grant[1], (r % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("tie_addr_%0d", r), abus[1], (r % 2 == 0) ? 7'h10 : 7'h20);
            while (grant[1] != 2'b00 && n < 16) begin tick(); n++; end
        end
        clr_reqs();
        tick();
        chk("tie_rdata0", m0_rdata[1], 0);
        chk("tie_rdata1", m1_rdata[1], 0);
        chk("tie_idle",   busy[1],     0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
